// File: rtl/enc_input_conditioner.sv
// enc_input_conditioner: synchronizes and debounces raw quadrature contacts into clean encoder levels,
// flagging each output update and any illegal step where both channels move together.
module enc_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic encRaw_X,
    input  logic encRaw_Y,
    input  logic errClear,
    output logic encInput_X,
    output logic encInput_Y,
    output logic encChange,
    output logic encError,
    output logic encReady
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STARTUP, RUN} state_t;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sx, sy;
    logic [1:0] sync, pre, out, out_nx, upd;
    logic [CW-1:0] st_cnt, st_cnt_nx;
    logic [CW-1:0] cnt [2];
    logic [CW-1:0] cnt_nx [2];
    logic chg, chg_nx, err, err_nx, rdy, rdy_nx, lock;

    // index 0 is channel X, index 1 is channel Y
    assign sync = {sy[SYNC_STAGES-1], sx[SYNC_STAGES-1]};
    // startup compares the value about to enter the last stage with the one already there
    assign pre  = {sy[SYNC_STAGES-2], sx[SYNC_STAGES-2]};

    always_comb begin
        state_nx  = state;
        st_cnt_nx = st_cnt;
        out_nx    = out;
        rdy_nx    = rdy;
        chg_nx    = 1'b0;
        err_nx    = err & ~errClear;
        lock      = 1'b0;
        upd       = '0;
        cnt_nx    = cnt;
        if (state == STARTUP) begin
            lock      = (pre == sync) && (st_cnt == LAST);
            st_cnt_nx = (pre != sync || lock) ? '0 : st_cnt + CW'(1);
            out_nx    = lock ? pre : out;
            rdy_nx    = rdy | lock;
            state_nx  = lock ? RUN : STARTUP;
        end else begin
            for (int i = 0; i < 2; i++) begin
                upd[i]    = (sync[i] != out[i]) && (cnt[i] == LAST);
                cnt_nx[i] = (sync[i] == out[i] || upd[i]) ? '0 : cnt[i] + CW'(1);
                out_nx[i] = upd[i] ? sync[i] : out[i];
            end
            chg_nx = |upd;
            err_nx = (&upd) | (err & ~errClear);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STARTUP;
            sx     <= '0;
            sy     <= '0;
            st_cnt <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
            out    <= '0;
            chg    <= 1'b0;
            err    <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            state  <= state_nx;
            sx     <= {sx[SYNC_STAGES-2:0], encRaw_X};
            sy     <= {sy[SYNC_STAGES-2:0], encRaw_Y};
            st_cnt <= st_cnt_nx;
            cnt[0] <= cnt_nx[0];
            cnt[1] <= cnt_nx[1];
            out    <= out_nx;
            chg    <= chg_nx;
            err    <= err_nx;
            rdy    <= rdy_nx;
        end
    end

    assign encInput_X = out[0];
    assign encInput_Y = out[1];
    assign encChange  = chg;
    assign encError   = err;
    assign encReady   = rdy;
endmodule

// File: tb/tb_enc_input_conditioner.sv
// tb_enc_input_conditioner: scoreboard bench for the encoder input conditioner
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, so a clean raw change lands 6 edges later).
module tb_enc_input_conditioner;
    logic clk = 1'b0, rst_n = 1'b0, raw_x = 1'b0, raw_y = 1'b0, err_clr = 1'b0;
    logic x, y, chg, err, rdy;
    int cyc;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic x;
        logic y;
        logic err;
        int   at_edge;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    enc_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .encRaw_X(raw_x), .encRaw_Y(raw_y), .errClear(err_clr),
        .encInput_X(x), .encInput_Y(y), .encChange(chg), .encError(err), .encReady(rdy)
    );

    always #5 clk = ~clk;

    // edge number since reset release; read at negedge, cyc == N means just after edge N
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic px, input logic py, input logic perr, input int pe);
        sb.push_back('{px, py, perr, pe});
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && chg) begin
            if (sb.size() == 0) begin
                check("spurious_change", 1, 0);
            end else begin
                e = sb.pop_front();
                check("change_edge", cyc, e.at_edge);
                check("out_x", x, e.x);
                check("out_y", y, e.y);
                check("error", err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        raw_x = 1'b1;
        raw_y = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", rdy, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_change", chg, 0);
        check("rst_error", err, 0);
        rst_n = 1'b1;
        wait_to(5);
        check("startup_ready_e5", rdy, 0);
        check("startup_x_e5", x, 0);
        wait_to(6);
        check("startup_ready_e6", rdy, 1);
        check("startup_x_e6", x, 1);
        check("startup_y_e6", y, 1);
        check("startup_no_change", chg, 0);
        wait_to(8);
        check("startup_no_error", err, 0);

        rst_n = 1'b0;
        raw_x = 1'b0;
        raw_y = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_to(10);
        check("lock_00_ready", rdy, 1);
        raw_x = 1'b1;
        push(1, 0, 0, 16);
        wait_to(15);
        check("latency_x_e15", x, 0);
        wait_to(17);
        check("change_one_cycle", chg, 0);
        check("latency_x_e17", x, 1);

        wait_to(20);
        raw_x = 1'b0;
        push(0, 0, 0, 26);
        wait_to(30);
        raw_x = 1'b1;
        wait_to(33);
        raw_x = 1'b0;
        wait_to(34);
        raw_x = 1'b1;
        push(1, 0, 0, 40);
        wait_to(39);
        check("bounce_hold_x", x, 0);

        wait_to(50);
        raw_x = 1'b0;
        raw_y = 1'b1;
        push(0, 1, 1, 56);
        wait_to(58);
        check("error_sticky", err, 1);
        wait_to(60);
        err_clr = 1'b1;
        wait_to(61);
        err_clr = 1'b0;
        check("error_cleared", err, 0);

        wait_to(70);
        raw_x = 1'b1;
        raw_y = 1'b0;
        push(1, 0, 1, 76);
        wait_to(75);
        err_clr = 1'b1;
        wait_to(76);
        err_clr = 1'b0;
        check("error_set_wins", err, 1);
        wait_to(80);
        err_clr = 1'b1;
        wait_to(81);
        err_clr = 1'b0;
        check("error_cleared_2", err, 0);

        wait_to(90);
        raw_x = 1'b0;
        push(0, 0, 0, 96);
        wait_to(100);
        raw_y = 1'b1;
        push(0, 1, 0, 106);
        wait_to(110);
        raw_x = 1'b1;
        push(1, 1, 0, 116);
        wait_to(120);
        raw_y = 1'b0;
        push(1, 0, 0, 126);
        wait_to(130);
        raw_x = 1'b0;
        push(0, 0, 0, 136);

        wait_to(140);
        raw_y = 1'b1;
        push(0, 1, 0, 146);
        wait_to(150);
        raw_x = 1'b1;
        wait_to(154);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", rdy, 0);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_change", chg, 0);
        check("midrst_error", err, 0);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_to(5);
        check("relock_ready_e5", rdy, 0);
        wait_to(6);
        check("relock_ready_e6", rdy, 1);
        check("relock_x", x, 1);
        check("relock_y", y, 1);
        wait_to(12);
        check("relock_no_change", chg, 0);
        check("relock_no_error", err, 0);
        check("scoreboard_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
